// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a runtime amount, STEP bit positions per cycle,
// valid/ready handshake on both sides.
//   state | meaning
//   IDLE  | ready for a request; latches operand, amount and op on in_valid
//   SHIFT | shifting by min(STEP, remaining) each edge
//   DONE  | result presented until out_ready
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [SHAMT_W-1:0] STEP_S  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WIDTH_X = (SHAMT_W+1)'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               carry_q, carry_d;

  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W:0]   wk;
  logic [WIDTH-1:0]   sll_v, srl_v, sra_v, rol_v, hi_out, lo_out;
  logic [WIDTH:0]     sra_x;

  // Per-step shift datapath; k is only meaningful (>=1) while in SHIFT.
  always_comb begin
    k      = (rem_q < STEP_S) ? rem_q : STEP_S;
    wk     = WIDTH_X - {1'b0, k};
    sll_v  = data_q << k;
    srl_v  = data_q >> k;
    sra_x  = $signed({sign_q, data_q}) >>> k;
    sra_v  = sra_x[WIDTH-1:0];
    rol_v  = (data_q << k) | (data_q >> wk);
    hi_out = data_q >> wk;
    lo_out = data_q >> (k - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          op_d    = in_op;
          sign_d  = in_data[WIDTH-1];
          carry_d = 1'b0;
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SLL: begin
            data_d  = sll_v;
            carry_d = hi_out[0];
          end
          OP_SRL: begin
            data_d  = srl_v;
            carry_d = lo_out[0];
          end
          OP_SRA: begin
            data_d  = sra_v;
            carry_d = lo_out[0];
          end
          default: begin
            data_d  = rol_v;
            carry_d = rol_v[0];
          end
        endcase
        rem_d = rem_q - k;
        if (rem_q <= STEP_S) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= 2'b00;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: three instances with STEP=1, 4 and 7 share operand
// inputs; each has its own handshake signals.
module tb_seq_shift_unit;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        in_valid_a[3];
  logic        out_ready_a[3];
  logic        in_ready_a[3];
  logic        out_valid_a[3];
  logic [31:0] out_data_a[3];
  logic        out_carry_a[3];
  logic        out_zero_a[3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_step1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_data(out_data_a[0]), .out_carry(out_carry_a[0]), .out_zero(out_zero_a[0])
  );

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_step4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_data(out_data_a[1]), .out_carry(out_carry_a[1]), .out_zero(out_zero_a[1])
  );

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(7)) u_step7 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .out_data(out_data_a[2]), .out_carry(out_carry_a[2]), .out_zero(out_zero_a[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input int u);
    check_val("rst_in_ready", in_ready_a[u], 1);
    check_val("rst_out_valid", out_valid_a[u], 0);
    check_val("rst_out_data", out_data_a[u], 0);
    check_val("rst_out_carry", out_carry_a[u], 0);
    check_val("rst_out_zero", out_zero_a[u], 1);
  endtask

  task automatic start_op(input int u, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh);
    @(negedge clk);
    check_val("in_ready_idle", in_ready_a[u], 1);
    in_data        = d;
    in_shamt       = sh;
    in_op          = op;
    in_valid_a[u]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[u]  = 1'b0;
  endtask

  // Edges counted from the accepting edge (which counts as 1) until out_valid is seen.
  task automatic wait_valid(input int u, output int n);
    n = 1;
    while (!out_valid_a[u] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("out_valid_seen", out_valid_a[u], 1);
  endtask

  task automatic run_op(input string tag, input int u, input logic [1:0] op,
                        input logic [31:0] d, input logic [4:0] sh,
                        input logic [31:0] exp_d, input logic exp_c, input int exp_lat);
    int n;
    start_op(u, op, d, sh);
    wait_valid(u, n);
    check_val({tag, "_latency"}, n, exp_lat);
    check_val({tag, "_data"}, out_data_a[u], exp_d);
    check_val({tag, "_carry"}, out_carry_a[u], exp_c);
    check_val({tag, "_zero"}, out_zero_a[u], exp_d == 32'h0);
    @(posedge clk);
    #1;
    check_val({tag, "_back_idle"}, in_ready_a[u], 1);
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    in_data  = '0;
    in_shamt = '0;
    in_op    = SLL;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset(0);

    // Basic ops, STEP=1
    run_op("sll2",    0, SLL, 32'h2345F000, 5'd2,  32'h8D17C000, 1'b0, 3);
    run_op("sra4",    0, SRA, 32'h81234011, 5'd4,  32'hF8123401, 1'b0, 5);
    run_op("srl4",    0, SRL, 32'h81234011, 5'd4,  32'h08123401, 1'b0, 5);
    run_op("rol1",    0, ROL, 32'hAAAA9999, 5'd1,  32'h55553333, 1'b1, 2);
    run_op("srl31",   0, SRL, 32'h89018310, 5'd31, 32'h00000001, 1'b0, 32);
    run_op("sll0",    0, SLL, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1);
    run_op("sll_c1",  0, SLL, 32'h40000000, 5'd2,  32'h00000000, 1'b1, 3);
    run_op("sra31",   0, SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 32);
    run_op("rol31",   0, ROL, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 32);
    run_op("srl1_c",  0, SRL, 32'h00000003, 5'd1,  32'h00000001, 1'b1, 2);

    // Wider steps: identical results, shorter latency
    run_op("s4_rol1",  1, ROL, 32'hAAAA9999, 5'd1,  32'h55553333, 1'b1, 2);
    run_op("s4_srl31", 1, SRL, 32'h89018310, 5'd31, 32'h00000001, 1'b0, 9);
    run_op("s4_sra31", 1, SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 9);
    run_op("s4_sll5",  1, SLL, 32'h0C000001, 5'd5,  32'h80000020, 1'b1, 3);
    run_op("s7_rol1",  2, ROL, 32'hAAAA9999, 5'd1,  32'h55553333, 1'b1, 2);
    run_op("s7_srl31", 2, SRL, 32'h89018310, 5'd31, 32'h00000001, 1'b0, 6);
    run_op("s7_rol31", 2, ROL, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 6);
    run_op("s7_sra9",  2, SRA, 32'h80000100, 5'd9,  32'hFFC00000, 1'b1, 3);

    // Backpressure: DONE holds, in_valid ignored
    out_ready_a[0] = 1'b0;
    start_op(0, SLL, 32'h2345F000, 5'd2);
    wait_valid(0, n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_a[0] = 1'b1;
      in_data       = 32'hFFFFFFFF;
      in_shamt      = 5'd0;
      in_op         = ROL;
      @(posedge clk);
      #1;
      in_valid_a[0] = 1'b0;
      check_val("hold_valid", out_valid_a[0], 1);
      check_val("hold_ready", in_ready_a[0], 0);
      check_val("hold_data", out_data_a[0], 32'h8D17C000);
      check_val("hold_carry", out_carry_a[0], 0);
    end
    // Release with a new request already pending: taken one cycle later, from IDLE
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    in_valid_a[0]  = 1'b1;
    in_data        = 32'h00000003;
    in_shamt       = 5'd1;
    in_op          = SLL;
    @(posedge clk);
    #1;
    check_val("rel_in_ready", in_ready_a[0], 1);
    check_val("rel_out_valid", out_valid_a[0], 0);
    check_val("rel_data_kept", out_data_a[0], 32'h8D17C000);
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    check_val("rel_accepted", in_ready_a[0], 0);
    wait_valid(0, n);
    check_val("rel_latency", n, 2);
    check_val("rel_data", out_data_a[0], 32'h00000006);
    check_val("rel_carry", out_carry_a[0], 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-shift (after 5 of 31 steps)
    start_op(0, SRL, 32'h89018310, 5'd31);
    repeat (5) @(posedge clk);
    #2;
    check_val("pre_rst_data", out_data_a[0], 32'h89018310 >> 5);
    check_val("pre_rst_busy", in_ready_a[0], 0);
    reset_n = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post_rst_sll3", 0, SLL, 32'h00000001, 5'd3, 32'h00000008, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
